// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a valid/ready
// request/response pair, with fixed response latency and byte/half/word
// lanes. Optional build macro: DMEM_MISALIGN_TRAP_EN (faults misaligned
// half/word accesses instead of aligning them down).
//
// Handshake: a request is accepted on the rising edge where
// req_valid && req_ready; a response is consumed on the rising edge where
// rsp_valid && rsp_ready. Neither side may withdraw a raised valid before
// its handshake edge, and the payload is stable while valid is high.
// fsm_state exposes the controller state (0 IDLE, 1 WAIT, 2 RESP).
module data_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  fsm_state
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_resp;

  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [1:0]       off;
  logic [3:0]       be;
  logic             oob, bad_size, misalign, access_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, rd_shift, load_data, wdata_sh;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [MEM_WORDS];

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // live request inputs are used in IDLE and the captured copy otherwise.
  always_comb begin
    cur_we    = we_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  // Lane decode, fault detection and load-data alignment.
  always_comb begin
    off = 2'b00;
    be  = 4'b0000;
    case (cur_size)
      2'b00: begin off = cur_addr[1:0];        be = 4'b0001 << cur_addr[1:0]; end
      2'b01: begin off = {cur_addr[1], 1'b0};  be = cur_addr[1] ? 4'b1100 : 4'b0011; end
      2'b10: begin off = 2'b00;                be = 4'b1111; end
      default: begin off = 2'b00;              be = 4'b0000; end
    endcase
    oob      = {2'b00, cur_addr[31:2]} >= 32'(MEM_WORDS);
    bad_size = (cur_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
               ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    access_err = oob || bad_size || misalign;
    idx        = cur_addr[IDX_W+1:2];
    rd_word    = mem[idx];
    rd_shift   = rd_word >> {off, 3'b000};
    case (cur_size)
      2'b00:   load_data = {24'h0, rd_shift[7:0]};
      2'b01:   load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
    wdata_sh = cur_wdata << {off, 3'b000};
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, request capture and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (access_err || cur_we) ? 32'h0 : load_data;
        err_q   <= access_err;
      end
    end
  end

  // Storage array: never cleared, written only on an error-free store
  // at the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_we && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = rst && (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 4), a
// directed vector table, mid-transaction reset sequences and randomized
// traffic checked against a byte-level memory model.
module tb_data_mem_responder;

  localparam int MW = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  fsm_state [2];

  int lat_of [2] = '{2, 4};
  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][MW];

  data_mem_responder #(.MEM_WORDS(MW), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .fsm_state(fsm_state[0])
  );

  data_mem_responder #(.MEM_WORDS(MW), .LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .fsm_state(fsm_state[1])
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: byte-granular access derived from size and address.
  function automatic logic [32:0] model_txn(input int d, input logic we, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    int nb, a, off, idx;
    bit err;
    r   = 32'h0;
    a   = int'(addr % 4);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr / 4) >= MW) ||
          (TRAP && ((size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && a != 0)));
    if (err) return {1'b1, 32'h0};
    off = (a / nb) * nb;
    idx = int'(addr / 4);
    for (int i = 0; i < nb; i++) begin
      if (we) mdl[d][idx][8*(off+i) +: 8] = wdata[8*i +: 8];
      else    r[8*i +: 8] = mdl[d][idx][8*(off+i) +: 8];
    end
    return {1'b0, we ? 32'h0 : r};
  endfunction

  // Driver: one complete request/response, holding rsp_ready low for
  // 'hold' cycles, checking latency, payload and ready/valid behaviour.
  task automatic run_txn(input int d, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         input logic exp_err, input logic [31:0] exp_rdata, input string name);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_addr[d] = addr;  req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    check({name, " accept_timeout"}, 32'(n >= 20), 32'd0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[d] && n < 20);
    check({name, " latency"}, 32'(n), 32'(lat_of[d]));
    if (!rsp_valid[d]) return;
    for (int h = 0; h <= hold; h++) begin
      check({name, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
      check({name, " rdata"}, rsp_rdata[d], exp_rdata);
      check({name, " err"}, 32'(rsp_err[d]), 32'(exp_err));
      check({name, " busy_ready"}, 32'(req_ready[d]), 32'd0);
      if (h == hold) rsp_ready[d] = 1'b1;
      @(negedge clk);
    end
    rsp_ready[d] = 1'b0;
    check({name, " valid_drop"}, 32'(rsp_valid[d]), 32'd0);
    check({name, " ready_back"}, 32'(req_ready[d]), 32'd1);
  endtask

  // Store 'old', start a store of 'new_val', reset one cycle after accept.
  task automatic reset_mid(input int d, input logic [31:0] addr,
                           input logic [31:0] old, input logic [31:0] new_val);
    logic [32:0] e;
    int n;
    e = model_txn(d, 1'b1, 2'd2, addr, old);
    run_txn(d, 1'b1, 2'd2, addr, old, 0, e[32], e[31:0], "rm_pre");
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_size[d] = 2'd2;
    req_addr[d] = addr;  req_wdata[d] = new_val;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
    @(negedge clk);
    check("rm_rst_ready", 32'(req_ready[d]), 32'd0);
    check("rm_rst_valid", 32'(rsp_valid[d]), 32'd0);
    check("rm_rst_rdata", rsp_rdata[d], 32'h0);
    check("rm_rst_err", 32'(rsp_err[d]), 32'd0);
    rst[d] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rm_no_rsp", 32'(rsp_valid[d]), 32'd0);
      check("rm_ready", 32'(req_ready[d]), 32'd1);
    end
    run_txn(d, 1'b0, 2'd2, addr, 32'h0, 0, 1'b0, old, "rm_load_old");
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic [32:0] e;
    logic [31:0] v33;
    v33 = TRAP ? 32'hDE55BEEF : 32'h12345678;
    vecs[0]  = '{1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 32'h40, 32'h0, 0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd0, 32'h42, 32'h00000055, 0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'd2, 32'h40, 32'h0, 5, 1'b0, 32'hDE55BEEF};
    vecs[4]  = '{1'b0, 2'd0, 32'h43, 32'h0, 0, 1'b0, 32'h000000DE};
    vecs[5]  = '{1'b0, 2'd1, 32'h42, 32'h0, 0, 1'b0, 32'h0000DE55};
    vecs[6]  = '{1'b1, 2'd2, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 32'h1000, 32'h0, 0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 32'h1000, 32'hFFFFFFFF, 1, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0, 32'h0BADF00D};
    vecs[10] = '{1'b1, 2'd2, 32'h42, 32'h12345678, 0, TRAP, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 32'h40, 32'h0, 0, 1'b0, v33};
    vecs[12] = '{1'b0, 2'd3, 32'h40, 32'h0, 0, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 2'd3, 32'h40, 32'hFFFFFFFF, 0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 32'h40, 32'h0, 2, 1'b0, v33};
    vecs[15] = '{1'b0, 2'd1, 32'h41, 32'h0, 0, TRAP, TRAP ? 32'h0 : 32'h00005678};
    vecs[16] = '{1'b1, 2'd2, 32'h44, 32'h00000000, 0, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 2'd1, 32'h46, 32'hAAAA1234, 0, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 2'd1, 32'h46, 32'h0, 0, 1'b0, 32'h00001234};
    vecs[19] = '{1'b0, 2'd2, 32'h44, 32'h0, 0, 1'b0, 32'h12340000};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", 32'(req_ready[d]), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      check("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      check("reset_state", 32'(fsm_state[d]), 32'd0);
      rst[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("post_reset_ready", 32'(req_ready[d]), 32'd1);

    // Directed table on the LATENCY=2 instance
    for (int i = 0; i < 20; i++) begin
      e = model_txn(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      run_txn(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
              vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Mid-transaction reset on both latencies
    reset_mid(1, 32'h80, 32'h11223344, 32'hCAFEF00D);
    reset_mid(0, 32'h84, 32'hA5A5A5A5, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 8; w++) begin
        logic [31:0] data;
        data = $urandom;
        e = model_txn(d, 1'b1, 2'd2, 32'(w * 4), data);
        run_txn(d, 1'b1, 2'd2, 32'(w * 4), data, 0, e[32], e[31:0], "rnd_init");
      end
      for (int t = 0; t < 40; t++) begin
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        int r;
        we    = 1'($urandom);
        size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        wdata = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 63));
        else if (r == 1) addr = $urandom | 32'h8000_0000;
        else             addr = 32'($urandom_range(0, 31));
        e = model_txn(d, we, size, addr, wdata);
        run_txn(d, we, size, addr, wdata, $urandom_range(0, 2), e[32], e[31:0],
                $sformatf("rnd_d%0d_t%0d", d, t));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got %0d want 0", 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning storage depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  the block can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0] encoding).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rsp_valid  output  1  a response is presented.
REQ-012 SHALL have port rsp_ready  input  1  the CPU accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, right-justified and zero-extended; sign extension is the CPU's job.
REQ-014 SHALL have port rsp_err  output  1  the access faulted; the CPU treats it as halt.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-016 Acceptance SHALL occur at the rising edge where req_valid&req_ready=1; req_we, req_size, req_addr and req_wdata SHALL be captured there, so inputs may change afterwards.
REQ-017 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge.
- LATENCY=1: IDLE goes directly to RESP.
- Otherwise WAIT uses a 4-bit down-counter loaded with LATENCY-1.
REQ-018 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until the edge with rsp_ready=1; the FSM then returns to IDLE.
- The earliest next acceptance is one cycle later; no same-cycle re-accept.
REQ-019 A store SHALL update memory at the edge entering RESP, byte-masked by size and addr[1:0]:
- byte: lane addr[1:0].
- half: lanes {addr[1],0} and {addr[1],1}.
- word: all four lanes.
- Other lanes SHALL be unchanged.
REQ-020 A load SHALL return the selected lane(s) shifted to bit 0 and zero-extended; store responses SHALL return rsp_rdata=0.
REQ-021 Word index addr[31:2] >= MEM_WORDS SHALL give rsp_err=1, rsp_rdata=0 and no memory write, with normal timing.
REQ-022 req_size=11 SHALL give rsp_err=1, rsp_rdata=0 and no write.
REQ-023 Outside RESP, rsp_valid, rsp_rdata and rsp_err SHALL be 0.
REQ-024 req_valid arriving while busy SHALL be ignored (not queued); the CPU holds it until req_ready.

Reset
REQ-025 While rst=0 at a rising edge:
- FSM SHALL go to IDLE and the counter to 0.
- Outputs SHALL be req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 In the first cycle after rst returns to 1, req_ready SHALL be 1.
REQ-027 Reset mid-transaction SHALL drop the transaction without a response.
- A store not yet at the RESP edge SHALL NOT be written.
- Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, SHALL give rsp_err=1, rsp_rdata=0 and no write.
- Undefined: misaligned low address bits SHALL be ignored and the access aligned down (half uses {addr[1],0}, word uses lane 0), with rsp_err=0.

Verification
REQ-029 Reset, then store word 0xDEADBEEF at 0x40 and load word 0x40 with LATENCY=2 -> rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF, err=0.
REQ-030 After REQ-029, store byte 0x55 at 0x42, then load word 0x40 -> 0xDE55BEEF; load byte 0x43 -> 0x000000DE; load half 0x42 -> 0x0000DE55.
REQ-031 Load word 0x40 with rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable throughout; req_ready=0 until the cycle after the rsp_ready handshake.
REQ-032 Load word at 0x1000 (MEM_WORDS=1024) -> err=1, rdata=0; store there -> err=1, and memory at 0x0 is unchanged afterwards.
REQ-033 Store word 0x12345678 at 0x42:
- With DMEM_MISALIGN_TRAP_EN: err=1, and a load of 0x40 returns the old value.
- Without it: err=0, and a load of 0x40 returns 0x12345678.
REQ-034 Accept a store of 0xCAFEF00D to 0x80 with LATENCY=4, assert rst=0 one cycle later, release -> no rsp_valid; req_ready=1 after release; load 0x80 returns the pre-existing contents.
